// File: rtl/and_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter in front of the shared AND unit.
// Holds the FSM state encoding, default sizes and the next-winner search.
package and_arb_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_N_REQ = 2;
  localparam int MAX_REQ   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First requester with valid set, searching ptr, ptr+1, ... modulo n.
  // Iterating from the far end down lets the closest candidate win the last write.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0]         ptr,
                                    input int                 n);
    pick_t p;
    int    cand;
    p = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= n) cand = cand - n;
      if (i < n && cand < MAX_REQ && valid[cand]) begin
        p.found = 1'b1;
        p.idx   = 3'(cand);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/and_unit.sv
// Shared combinational datapath: bitwise AND of two WIDTH-bit operands.
module and_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a & b;

endmodule

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter sharing one AND unit between N_REQ requesters, with a
// registered result held per requester until that requester's next completion.
module and_unit_arbiter
  import and_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_REQ = DEF_N_REQ,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [N_REQ*WIDTH-1:0] rsp_data,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic                   busy
);

  // Handshakes: a request transfers on the rising edge where req_valid[i] and
  // req_ready[i] are both high; a response transfers on the edge where
  // rsp_valid[i] and rsp_ready[i] are both high. Requesters hold operands
  // stable while valid and not yet ready.

  state_e           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;

  pick_t            pick;
  logic [PTR_W-1:0] winner;
  logic             take;
  logic             last_grant;

  always_comb begin
    pick   = rr_pick(MAX_REQ'(req_valid), 3'(ptr), N_REQ);
    winner = PTR_W'(pick.idx);
    take   = (state == IDLE) && pick.found;
  end

  always_comb begin
    req_ready = '0;
    if (take) req_ready[winner] = 1'b1;
  end

  assign busy       = (state != IDLE);
  assign last_grant = (grant == PTR_W'(N_REQ - 1));

  and_unit #(
    .WIDTH(WIDTH)
  ) u_and_unit (
    .a(op_a),
    .b(op_b),
    .y(result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            op_a  <= req_a[winner*WIDTH +: WIDTH];
            op_b  <= req_b[winner*WIDTH +: WIDTH];
            grant <= winner;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data[grant*WIDTH +: WIDTH] <= result;
          rsp_valid[grant]               <= 1'b1;
          state                          <= RESP;
        end
        RESP: begin
          // Only the granted requester's ack matters; others are ignored.
          if (rsp_ready[grant]) begin
            rsp_valid[grant] <= 1'b0;
            ptr              <= last_grant ? '0 : grant + 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_req_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

  a_rsp_valid_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(rsp_valid));

  // Operands stay captured through RESP, so the held result must match them.
  a_rsp_data_matches: assert property (@(posedge clk) disable iff (!rst_n)
    (state == RESP) |-> (rsp_data[grant*WIDTH +: WIDTH] == (op_a & op_b)));

endmodule
